// File: rtl/mrr_pathway_stream_arbiter_pkg.sv
// Shared constants and state encoding for the pathway stream arbiter.
// Build option: MRR_ARB_HEADER_TAG_EN prefixes every packet with a tag word.
package mrr_pathway_stream_arbiter_pkg;

   localparam int          NUM_DECODE_PATHWAYS = 4;
   localparam logic [7:0]  TAG_MAGIC           = 8'hA5;
   localparam logic [31:0] FILLER_BASE         = 32'hDEAD_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TAG   = 2'd1,
      ST_PASS  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mrr_rr_grant.sv
// Combinational round-robin picker: first request strictly after last_grant_i,
// wrapping modulo NUM_PATHWAYS.
module mrr_rr_grant #(
   parameter int NUM_PATHWAYS = 4,
   parameter int IDX_WIDTH    = 2
) (
   input  logic [NUM_PATHWAYS-1:0] req_i,
   input  logic [IDX_WIDTH-1:0]    last_grant_i,
   output logic                    any_o,
   output logic [IDX_WIDTH-1:0]    grant_o
);

   int cand;

   always_comb begin
      any_o   = 1'b0;
      grant_o = '0;
      cand    = 0;
      for (int i = 1; i <= NUM_PATHWAYS; i++) begin
         cand = int'(last_grant_i) + i;
         if (cand >= NUM_PATHWAYS) cand = cand - NUM_PATHWAYS;
         if (!any_o && req_i[cand[IDX_WIDTH-1:0]]) begin
            any_o   = 1'b1;
            grant_o = cand[IDX_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/mrr_pathway_stream_arbiter.sv
// Packet-level round-robin merge of per-pathway streams onto one AXI-Stream,
// with a stall watchdog. Optional tag prefix: `define MRR_ARB_HEADER_TAG_EN.
module mrr_pathway_stream_arbiter
   import mrr_pathway_stream_arbiter_pkg::*;
#(
   parameter int NUM_PATHWAYS   = NUM_DECODE_PATHWAYS,
   parameter int IDX_WIDTH      = (NUM_PATHWAYS > 1) ? $clog2(NUM_PATHWAYS) : 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [32*NUM_PATHWAYS-1:0] i_tdata,
   input  logic [NUM_PATHWAYS-1:0]   i_tkeep,
   input  logic [NUM_PATHWAYS-1:0]   i_tlast,
   input  logic [NUM_PATHWAYS-1:0]   i_tvalid,
   output logic [NUM_PATHWAYS-1:0]   i_tready,
   output logic [31:0]               o_tdata,
   output logic                      o_tkeep,
   output logic                      o_tlast,
   output logic                      o_tvalid,
   input  logic                      o_tready,
   output logic [IDX_WIDTH-1:0]      o_src_idx,
   output logic                      busy,
   input  logic                      clear_counters,
   output logic [15:0]               timeout_count
);

   localparam logic [31:0] STALL_LAST =
      (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   localparam logic [IDX_WIDTH-1:0] LAST_INIT = IDX_WIDTH'(NUM_PATHWAYS - 1);

   arb_state_e state_q, state_d;
   logic [IDX_WIDTH-1:0] g_q, g_d, last_q, last_d, src_q, gnt;
   logic [31:0] stall_q, stall_d, data_q, ld_data, sel_data;
   logic keep_q, olast_q, valid_q, ld_en, ld_keep, ld_last;
   logic [NUM_PATHWAYS-1:0][15:0] seq_q;
   logic [15:0] tcnt_q, sel_seq;
   logic any, sel_valid, sel_last, sel_keep, out_free, seq_inc, to_inc;
   logic [NUM_PATHWAYS-1:0] one_hot;

   mrr_rr_grant #(.NUM_PATHWAYS(NUM_PATHWAYS), .IDX_WIDTH(IDX_WIDTH)) u_grant (
      .req_i(i_tvalid), .last_grant_i(last_q), .any_o(any), .grant_o(gnt)
   );

   assign out_free = ~valid_q | o_tready;
   assign one_hot  = NUM_PATHWAYS'(1) << g_q;

   always_comb begin
      sel_data  = '0;
      sel_keep  = 1'b0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      sel_seq   = '0;
      for (int p = 0; p < NUM_PATHWAYS; p++) begin
         if (g_q == IDX_WIDTH'(p)) begin
            sel_data  = i_tdata[32*p +: 32];
            sel_keep  = i_tkeep[p];
            sel_last  = i_tlast[p];
            sel_valid = i_tvalid[p];
            sel_seq   = seq_q[p];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      last_d   = last_q;
      stall_d  = stall_q;
      i_tready = '0;
      ld_en    = 1'b0;
      ld_data  = '0;
      ld_keep  = 1'b0;
      ld_last  = 1'b0;
      seq_inc  = 1'b0;
      to_inc   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               g_d     = gnt;
               stall_d = '0;
`ifdef MRR_ARB_HEADER_TAG_EN
               state_d = ST_TAG;
`else
               state_d = ST_PASS;
`endif
            end
         end
`ifdef MRR_ARB_HEADER_TAG_EN
         ST_TAG: begin
            if (out_free) begin
               ld_en   = 1'b1;
               ld_data = {TAG_MAGIC, 8'(g_q), sel_seq};
               ld_keep = 1'b1;
               state_d = ST_PASS;
            end
         end
`endif
         ST_PASS: begin
            if (out_free) i_tready = one_hot;
            if (sel_valid && out_free) begin
               ld_en   = 1'b1;
               ld_data = sel_data;
               ld_keep = sel_keep;
               ld_last = sel_last;
               stall_d = '0;
               if (sel_last) begin
                  seq_inc = 1'b1;
                  last_d  = g_q;
                  state_d = ST_IDLE;
               end
            end else if (TIMEOUT_CYCLES > 0) begin
               // Counter parks at the limit so a blocked output still gets the filler later.
               if (stall_q == STALL_LAST) begin
                  if (out_free) begin
                     ld_en   = 1'b1;
                     ld_data = FILLER_BASE | 32'(g_q);
                     ld_last = 1'b1;
                     to_inc  = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end else begin
                  stall_d = stall_q + 32'd1;
               end
            end
         end
         ST_DRAIN: begin
            i_tready = one_hot;
            if (sel_valid && sel_last) begin
               seq_inc = 1'b1;
               last_d  = g_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         last_q  <= LAST_INIT;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         last_q  <= last_d;
         stall_q <= stall_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         keep_q  <= 1'b0;
         olast_q <= 1'b0;
         src_q   <= '0;
         valid_q <= 1'b0;
      end else if (ld_en) begin
         data_q  <= ld_data;
         keep_q  <= ld_keep;
         olast_q <= ld_last;
         src_q   <= g_q;
         valid_q <= 1'b1;
      end else if (o_tready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q  <= '0;
         tcnt_q <= '0;
      end else if (clear_counters) begin
         seq_q  <= '0;
         tcnt_q <= '0;
      end else begin
         if (seq_inc) begin
            for (int p = 0; p < NUM_PATHWAYS; p++)
               if (g_q == IDX_WIDTH'(p)) seq_q[p] <= seq_q[p] + 16'd1;
         end
         if (to_inc && tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
      end
   end

   assign o_tdata       = data_q;
   assign o_tkeep       = keep_q;
   assign o_tlast       = olast_q;
   assign o_tvalid      = valid_q;
   assign o_src_idx     = src_q;
   assign busy          = (state_q != ST_IDLE);
   assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_mrr_pathway_stream_arbiter.sv
// Directed bench for mrr_pathway_stream_arbiter (4 pathways, 1024-cycle watchdog).
module tb_mrr_pathway_stream_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] i_tdata = '0;
   logic [3:0]   i_tkeep = '0, i_tlast = '0, i_tvalid = '0, i_tready;
   logic [31:0]  o_tdata;
   logic         o_tkeep, o_tlast, o_tvalid, busy;
   logic         o_tready = 1'b1, clear_counters = 1'b0;
   logic [1:0]   o_src_idx;
   logic [15:0]  timeout_count;

   mrr_pathway_stream_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast),
      .o_tvalid(o_tvalid), .o_tready(o_tready), .o_src_idx(o_src_idx),
      .busy(busy), .clear_counters(clear_counters), .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] d; logic l; } w_t;
   typedef struct { logic [31:0] d; logic l; logic k; logic [1:0] s; int c; } o_t;

   w_t   srcq[4][$];
   o_t   outq[$];
   logic hs[4];
   int   cyc = 0;
   int   checks = 0, errors = 0;

   // Upstream sources: pop on handshake seen at the previous negedge, then present head.
   always @(posedge clk) begin
      #1;
      for (int p = 0; p < 4; p++) begin
         if (hs[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
         i_tvalid[p]          = (srcq[p].size() > 0);
         i_tkeep[p]           = (srcq[p].size() > 0);
         i_tlast[p]           = (srcq[p].size() > 0) ? srcq[p][0].l : 1'b0;
         i_tdata[32*p +: 32]  = (srcq[p].size() > 0) ? srcq[p][0].d : 32'h0;
      end
   end

   always @(negedge clk) begin
      cyc++;
      for (int p = 0; p < 4; p++) hs[p] = rst_n && i_tvalid[p] && i_tready[p];
      if (rst_n && o_tvalid && o_tready)
         outq.push_back('{o_tdata, o_tlast, o_tkeep, o_src_idx, cyc});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_out(input string tag, input int n, input int budget);
      int k = 0;
      while (outq.size() < n && k < budget) begin step(1); k++; end
      chk(tag, 32'(outq.size() >= n), 32'd1);
   endtask

   task automatic pop(output o_t e);
      if (outq.size() > 0) e = outq.pop_front();
      else e = '{32'hx, 1'bx, 1'bx, 2'bx, 0};
   endtask

   task automatic push(input int p, input logic [31:0] d, input logic l);
      srcq[p].push_back('{d, l});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int p = 0; p < 4; p++) srcq[p].delete();
      step(2);
      rst_n = 1'b1;
      outq.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      o_t e;
      o_t first;
      logic [31:0] snap;
      logic stable, rdy_low, vld_hi;

      repeat (3) @(negedge clk);
      chk("rst_tvalid", 32'(o_tvalid), 32'd0);
      chk("rst_tdata", o_tdata, 32'd0);
      chk("rst_tlast_tkeep", {30'd0, o_tlast, o_tkeep}, 32'd0);
      chk("rst_src", 32'(o_src_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tready", 32'(i_tready), 32'd0);
      chk("rst_tcount", 32'(timeout_count), 32'd0);
      step(1);
      rst_n = 1'b1;

`ifdef MRR_ARB_HEADER_TAG_EN
      // Tag word {A5, idx, seq} precedes each packet of pathway 3.
      push(3, 32'h7777_0001, 1'b1);
      wait_out("tag1_wait", 2, 40);
      pop(e);
      chk("tag1_word", e.d, 32'hA503_0000);
      chk("tag1_lastkeep", {30'd0, e.l, e.k}, 32'd1);
      chk("tag1_src", 32'(e.s), 32'd3);
      pop(e);
      chk("tag1_payload", e.d, 32'h7777_0001);
      chk("tag1_plast", 32'(e.l), 32'd1);
      push(3, 32'h7777_0002, 1'b0);
      push(3, 32'h7777_0003, 1'b1);
      wait_out("tag2_wait", 3, 40);
      pop(e);
      chk("tag2_word", e.d, 32'hA503_0001);
      pop(e);
      chk("tag2_p0", e.d, 32'h7777_0002);
      pop(e);
      chk("tag2_p1", e.d, 32'h7777_0003);
      chk("tag2_p1_last", 32'(e.l), 32'd1);
      step(5);
      chk("tag2_count", 32'(outq.size()), 32'd0);
`else
      // Two packets offered together: pathway 0 whole, then pathway 2 whole.
      for (int w = 0; w < 3; w++) push(0, 32'h0000_0A01 + 32'(w), w == 2);
      for (int w = 0; w < 3; w++) push(2, 32'h0000_0B01 + 32'(w), w == 2);
      wait_out("t1_wait", 6, 50);
      step(3);
      chk("t1_count", 32'(outq.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         pop(e);
         chk($sformatf("t1_data%0d", i), e.d,
             (i < 3) ? 32'h0000_0A01 + 32'(i) : 32'h0000_0B01 + 32'(i - 3));
         chk($sformatf("t1_src%0d", i), 32'(e.s), (i < 3) ? 32'd0 : 32'd2);
         chk($sformatf("t1_last%0d", i), 32'(e.l), 32'((i % 3) == 2));
      end

      // Continuous 2-word packets on all pathways: order 0,1,2,3,0,1,2,3.
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 4; p++)
            for (int w = 0; w < 2; w++)
               push(p, 32'h5000_0000 | 32'(p << 8) | 32'(r << 4) | 32'(w), w == 1);
      wait_out("t2_wait", 16, 100);
      step(3);
      chk("t2_count", 32'(outq.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         pop(e);
         if (i == 0) first = e;
         chk($sformatf("t2_src%0d", i), 32'(e.s), 32'((i / 2) % 4));
         chk($sformatf("t2_data%0d", i), e.d,
             32'h5000_0000 | 32'(((i / 2) % 4) << 8) | 32'(((i / 8)) << 4) | 32'(i % 2));
      end
      // 16 words plus one bubble between each of the 8 packets.
      chk("t2_span", 32'(e.c - first.c), 32'd22);

      // Pathway 1 stalls mid-packet: filler, drop of the late tail, then normal traffic.
      push(1, 32'h1111_0001, 1'b0);
      wait_out("t3_wait", 2, 1200);
      pop(e);
      chk("t3_w1", e.d, 32'h1111_0001);
      chk("t3_w1_lastkeep", {30'd0, e.l, e.k}, 32'd1);
      pop(e);
      chk("t3_filler", e.d, 32'hDEAD_0001);
      chk("t3_filler_lastkeep", {30'd0, e.l, e.k}, 32'd2);
      chk("t3_filler_src", 32'(e.s), 32'd1);
      chk("t3_tcount", 32'(timeout_count), 32'd1);
      chk("t3_busy_drain", 32'(busy), 32'd1);
      push(1, 32'h1111_0002, 1'b0);
      push(1, 32'h1111_0003, 1'b1);
      push(1, 32'h2222_0001, 1'b1);
      wait_out("t3_next_wait", 1, 40);
      step(5);
      chk("t3_after_count", 32'(outq.size()), 32'd1);
      pop(e);
      chk("t3_next", e.d, 32'h2222_0001);
      chk("t3_next_last", 32'(e.l), 32'd1);
      clear_counters = 1'b1;
      step(1);
      clear_counters = 1'b0;
      chk("t3_clear", 32'(timeout_count), 32'd0);

      // Downstream backpressure for 10 cycles mid-packet.
      for (int w = 0; w < 5; w++) push(2, 32'h3333_0001 + 32'(w), w == 4);
      wait_out("t4_wait", 1, 40);
      o_tready = 1'b0;
      stable = 1'b1; rdy_low = 1'b1; vld_hi = 1'b1;
      @(negedge clk);
      snap = o_tdata;
      repeat (10) begin
         @(negedge clk);
         if (o_tdata !== snap) stable = 1'b0;
         if (i_tready[2] !== 1'b0) rdy_low = 1'b0;
         if (o_tvalid !== 1'b1) vld_hi = 1'b0;
      end
      chk("t4_stable", 32'(stable), 32'd1);
      chk("t4_tready_low", 32'(rdy_low), 32'd1);
      chk("t4_valid_held", 32'(vld_hi), 32'd1);
      step(1);
      o_tready = 1'b1;
      wait_out("t4_wait_all", 5, 40);
      step(3);
      chk("t4_count", 32'(outq.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         pop(e);
         chk($sformatf("t4_data%0d", i), e.d, 32'h3333_0001 + 32'(i));
      end

      // Reset during PASS, then arbitration restarts at pathway 0.
      for (int w = 0; w < 4; w++) push(3, 32'h4444_0001 + 32'(w), w == 3);
      wait_out("t5_wait", 1, 40);
      rst_n = 1'b0;
      #1;
      chk("t5_tvalid", 32'(o_tvalid), 32'd0);
      chk("t5_tdata", o_tdata, 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_tready", 32'(i_tready), 32'd0);
      for (int p = 0; p < 4; p++) srcq[p].delete();
      step(2);
      rst_n = 1'b1;
      outq.delete();
      push(2, 32'h6666_0002, 1'b1);
      push(0, 32'h6666_0000, 1'b1);
      wait_out("t5_after_wait", 2, 40);
      pop(e);
      chk("t5_first_src", 32'(e.s), 32'd0);
      chk("t5_first_data", e.d, 32'h6666_0000);
      pop(e);
      chk("t5_second_src", 32'(e.s), 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
